// File: rtl/bm_stripe_mac.sv
// Bitmatrix multiply-accumulate engine: XOR-folds GF(2) bitmatrix products of up to K data
// blocks into one parity block, then presents it with a valid/ready handshake.
module bm_stripe_mac #(
    parameter int unsigned W             = 8,
    parameter int unsigned PACKET_LENGTH = 32,
    parameter int unsigned K             = 4,
    localparam int unsigned CW           = $clog2(K + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       in_last_i,
    input  logic [W*W-1:0]             in_bitmatrix_i,
    input  logic [W*PACKET_LENGTH-1:0] in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [W*PACKET_LENGTH-1:0] out_parity_o,
    output logic [CW-1:0]              out_beats_o
);

    localparam logic [0:0] StAccum = 1'b0;
    localparam logic [0:0] StOut   = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [CW-1:0]            beats_q, beats_d;
    logic [W*PACKET_LENGTH-1:0] acc_q, acc_d;
    logic [W*PACKET_LENGTH-1:0] prod;

    // prod[r] = XOR of every data packet c selected by row r of the bitmatrix
    always_comb begin
        prod = '0;
        for (int unsigned r = 0; r < W; r++) begin
            for (int unsigned c = 0; c < W; c++) begin
                if (in_bitmatrix_i[r*W+c]) begin
                    prod[r*PACKET_LENGTH +: PACKET_LENGTH] =
                        prod[r*PACKET_LENGTH +: PACKET_LENGTH] ^
                        in_data_i[c*PACKET_LENGTH +: PACKET_LENGTH];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        acc_d   = acc_q;
        case (state_q)
            StAccum: begin
                if (clr_i) begin
                    cnt_d = '0;
                    acc_d = '0;
                end else if (in_valid_i) begin
                    acc_d = (cnt_q == '0) ? prod : (acc_q ^ prod);
                    cnt_d = cnt_q + CW'(1);
                    if (in_last_i || (cnt_q == CW'(K - 1))) begin
                        state_d = StOut;
                        beats_d = cnt_q + CW'(1);
                        cnt_d   = '0;
                    end
                end
            end
            StOut: begin
                if (out_ready_i) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAccum;
            cnt_q   <= '0;
            beats_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready_o   = (state_q == StAccum) && !clr_i;
    assign out_valid_o  = (state_q == StOut);
    // The accumulator holds the finished parity for the whole OUT phase.
    assign out_parity_o = acc_q;
    assign out_beats_o  = beats_q;

endmodule

// File: tb/tb_bm_stripe_mac.sv
// Self-checking bench for bm_stripe_mac (W=4, PACKET_LENGTH=8, K=4): a stripe-level model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_bm_stripe_mac;

    localparam int W  = 4;
    localparam int PL = 8;
    localparam int K  = 4;
    localparam int CW = $clog2(K + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [W*W-1:0]    in_bitmatrix = '0;
    logic [W*PL-1:0]   in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [W*PL-1:0]   out_parity;
    logic [CW-1:0]     out_beats;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] IDENT = 16'h8421;
    localparam logic [31:0] DATA1 = 32'h88442211;

    bm_stripe_mac #(
        .W             (W),
        .PACKET_LENGTH (PL),
        .K             (K)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr_i          (clr),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_last_i      (in_last),
        .in_bitmatrix_i (in_bitmatrix),
        .in_data_i      (in_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_parity_o   (out_parity),
        .out_beats_o    (out_beats)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // GF(2) matrix-vector product over packets.
    function automatic logic [W*PL-1:0] gf_mul(input logic [W*W-1:0] m, input logic [W*PL-1:0] d);
        logic [W*PL-1:0] p;
        p = '0;
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                if (m[r*W+c]) p[r*PL +: PL] ^= d[c*PL +: PL];
        return p;
    endfunction

    // Stripe-level model: running XOR of accepted products and a pending-parity slot.
    bit              m_pend  = 1'b0;
    logic [W*PL-1:0] m_acc   = '0;
    int              m_n     = 0;
    logic [W*PL-1:0] m_par   = '0;
    int              m_beats = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 1'b0; m_acc = '0; m_n = 0; m_par = '0; m_beats = 0;
        end else if (m_pend) begin
            if (out_ready) m_pend = 1'b0;
        end else if (clr) begin
            m_acc = '0; m_n = 0;
        end else if (in_valid) begin
            m_acc ^= gf_mul(in_bitmatrix, in_data);
            m_n++;
            if (in_last || m_n == K) begin
                m_pend = 1'b1; m_par = m_acc; m_beats = m_n; m_acc = '0; m_n = 0;
            end
        end
    end

    initial begin
        @(negedge clk);
        forever begin
            @(negedge clk);
            #1;
            check("model in_ready", 64'(in_ready), 64'(!m_pend && !clr));
            check("model out_valid", 64'(out_valid), 64'(m_pend));
            if (m_pend) begin
                check("model out_parity", 64'(out_parity), 64'(m_par));
                check("model out_beats", 64'(out_beats), 64'(m_beats));
            end
        end
    end

    task automatic beat(input logic [15:0] m, input logic [31:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1; in_bitmatrix = m; in_data = d; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_parity", 64'(out_parity), 64'd0);
        check("reset out_beats", 64'(out_beats), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: identity, single beat with in_last
        beat(IDENT, DATA1, 1'b1);
        check("t1 out_valid", 64'(out_valid), 64'd1);
        check("t1 parity", 64'(out_parity), 64'h88442211);
        check("t1 beats", 64'(out_beats), 64'd1);

        // 2: row 0 all ones
        beat(16'h000F, DATA1, 1'b1);
        check("t2 parity", 64'(out_parity), 64'h000000FF);

        // 3: A,B,A,B with no in_last -> auto close, parity cancels
        beat(IDENT, 32'h12345678, 1'b0);
        beat(IDENT, 32'h9ABCDEF0, 1'b0);
        beat(IDENT, 32'h12345678, 1'b0);
        check("t3 no early close", 64'(out_valid), 64'd0);
        beat(IDENT, 32'h9ABCDEF0, 1'b0);
        check("t3 out_valid", 64'(out_valid), 64'd1);
        check("t3 parity", 64'(out_parity), 64'd0);
        check("t3 beats", 64'(out_beats), 64'd4);

        // 4: back-pressure on the output
        @(negedge clk);
        out_ready = 1'b0;
        beat(IDENT, DATA1, 1'b1);
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_bitmatrix = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("t4 hold valid", 64'(out_valid), 64'd1);
            check("t4 hold parity", 64'(out_parity), 64'h88442211);
            check("t4 in_ready low", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("t4 in_ready after handshake", 64'(in_ready), 64'd1);
        check("t4 out_valid after handshake", 64'(out_valid), 64'd0);

        // 5: clr drops partial stripe and the simultaneous beat
        beat(IDENT, 32'hFFFFFFFF, 1'b0);
        beat(16'hFFFF, 32'h01020304, 1'b0);
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; in_bitmatrix = IDENT; in_data = 32'h55555555;
        #1;
        check("t5 in_ready during clr", 64'(in_ready), 64'd0);
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        beat(IDENT, 32'h0F0F0F0F, 1'b1);
        check("t5 parity", 64'(out_parity), 64'h0F0F0F0F);
        check("t5 beats", 64'(out_beats), 64'd1);

        // 6: reset mid-stripe
        beat(IDENT, 32'hA5A5A5A5, 1'b0);
        beat(IDENT, 32'h3C3C3C3C, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6 out_valid in reset", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6 in_ready after reset", 64'(in_ready), 64'd1);
        beat(IDENT, DATA1, 1'b0);
        beat(16'h000F, DATA1, 1'b1);
        check("t6 parity", 64'(out_parity), 64'h884422EE);
        check("t6 beats", 64'(out_beats), 64'd2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
